// File: rtl/scorekeeper.sv
`default_nettype none
// ============================================================================
// Module   : scorekeeper
// Brief    : Breakout-style score, lives and serve sequencing for a scoreboard.
// Revision : 1.0
// ============================================================================
module scorekeeper #(
    parameter int START_LIVES  = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int BONUS_TENS   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic       new_game,
    input  logic       brick_hit,
    input  logic       ball_lost,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] lives,
    output logic       playing,
    output logic       game_over,
    output logic       serve
);

    localparam logic [3:0] c_START_LIVES  = 4'(START_LIVES);
    localparam logic [3:0] c_BONUS_TENS   = 4'(BONUS_TENS);
    localparam logic [7:0] c_SERVE_FRAMES = 8'(SERVE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] score0_q, score0_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] lives_q, lives_d;
    logic       bonus_q, bonus_d;
    logic [7:0] cnt_q, cnt_d;
    logic       serve_q, serve_d;
    logic       playing_q, over_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            score0_q  <= 4'd0;
            score1_q  <= 4'd0;
            lives_q   <= c_START_LIVES;
            bonus_q   <= 1'b0;
            cnt_q     <= 8'd0;
            serve_q   <= 1'b0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score0_q  <= score0_d;
            score1_q  <= score1_d;
            lives_q   <= lives_d;
            bonus_q   <= bonus_d;
            cnt_q     <= cnt_d;
            serve_q   <= serve_d;
            playing_q <= (state_d == S_PLAY);
            over_q    <= (state_d == S_OVER);
        end
    end

    always_comb begin
        state_d  = state_q;
        score0_d = score0_q;
        score1_d = score1_q;
        lives_d  = lives_q;
        bonus_d  = bonus_q;
        cnt_d    = cnt_q;
        serve_d  = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (new_game) begin
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                    lives_d  = c_START_LIVES;
                    bonus_d  = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = S_SERVE;
                end
            end
            S_SERVE: begin
                if (frame) begin
                    if (cnt_q + 8'd1 == c_SERVE_FRAMES) begin
                        serve_d = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // The point (and any bonus) lands first; a same-cycle ball loss
                // then acts on the updated life count.
                if (brick_hit && !(score1_q == 4'd9 && score0_q == 4'd9)) begin
                    if (score0_q == 4'd9) begin
                        score0_d = 4'd0;
                        score1_d = score1_q + 4'd1;
                    end else begin
                        score0_d = score0_q + 4'd1;
                    end
                    if (score0_d == 4'd0 && score1_d == c_BONUS_TENS && !bonus_q) begin
                        bonus_d = 1'b1;
                        if (lives_q != 4'd9) begin
                            lives_d = lives_q + 4'd1;
                        end
                    end
                end
                if (ball_lost) begin
                    if (lives_d > 4'd1) begin
                        lives_d = lives_d - 4'd1;
                        state_d = S_SERVE;
                    end else begin
                        lives_d = 4'd0;
                        state_d = S_OVER;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign score0    = score0_q;
    assign score1    = score1_q;
    assign lives     = lives_q;
    assign playing   = playing_q;
    assign game_over = over_q;
    assign serve     = serve_q;

endmodule
`default_nettype wire
